// File: rtl/csr_write_unit.sv
// Machine-mode CSR read-modify-write unit owning mstatus/mie/mtvec/mscratch/mepc/mcause and mcycle/minstret.
// Define CSR_CNT_INHIBIT_EN to add mcountinhibit (0x320); otherwise that address is unmapped.
module csr_write_unit #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter int unsigned CYCLE_OFFSET = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_src_zero,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        retire,
    output logic        mstatus_mie,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [1:0]  op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        src_zero_q, src_zero_d;
    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [2:0]  irq_en_q, irq_en_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic [31:0] mtvec_out_q, mtvec_out_d;
    logic [31:0] mepc_out_q, mepc_out_d;
`ifdef CSR_CNT_INHIBIT_EN
    logic        cy_inh_q, cy_inh_d;
    logic        ir_inh_q, ir_inh_d;
`endif

    logic [63:0] cycle_rd;
    logic [31:0] old_val, new_val;
    logic        hit, ro, do_write, err, wr_en;

    assign cycle_rd = mcycle_q - 64'(CYCLE_OFFSET);

    always_comb begin
        old_val = '0;
        hit     = 1'b0;
        ro      = 1'b0;
        case (addr_q)
            12'h300: begin hit = 1'b1; old_val = {24'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0}; end
            12'h304: begin
                hit     = 1'b1;
                old_val = {20'b0, irq_en_q[2], 3'b0, irq_en_q[1], 3'b0, irq_en_q[0], 3'b0};
            end
            12'h305: begin hit = 1'b1; old_val = mtvec_q; end
`ifdef CSR_CNT_INHIBIT_EN
            12'h320: begin hit = 1'b1; old_val = {29'b0, ir_inh_q, 1'b0, cy_inh_q}; end
`endif
            12'h340: begin hit = 1'b1; old_val = mscratch_q; end
            12'h341: begin hit = 1'b1; old_val = mepc_q; end
            12'h342: begin hit = 1'b1; old_val = mcause_q; end
            12'hB00: begin hit = 1'b1; old_val = cycle_rd[31:0]; end
            12'hB80: begin hit = 1'b1; old_val = cycle_rd[63:32]; end
            12'hB02: begin hit = 1'b1; old_val = minstret_q[31:0]; end
            12'hB82: begin hit = 1'b1; old_val = minstret_q[63:32]; end
            12'hC00: begin hit = 1'b1; ro = 1'b1; old_val = cycle_rd[31:0]; end
            12'hC80: begin hit = 1'b1; ro = 1'b1; old_val = cycle_rd[63:32]; end
            12'hC02: begin hit = 1'b1; ro = 1'b1; old_val = minstret_q[31:0]; end
            12'hC82: begin hit = 1'b1; ro = 1'b1; old_val = minstret_q[63:32]; end
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_RW:   new_val = wdata_q;
            OP_RS:   new_val = old_val | wdata_q;
            default: new_val = old_val & ~wdata_q;
        endcase
    end

    // RS/RC with a zero source only reads, so read-only targets stay legal
    assign do_write = (op_q == OP_RW) || !src_zero_q;
    assign err      = !hit || (op_q == 2'b00) || (do_write && ro);
    assign wr_en    = (state_q == EXEC) && !err && do_write;

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        src_zero_d    = src_zero_q;
        mst_mie_d     = mst_mie_q;
        mst_mpie_d    = mst_mpie_q;
        irq_en_d      = irq_en_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mcycle_d      = mcycle_q + 64'd1;
        minstret_d    = minstret_q + {63'b0, retire};
        mstatus_mie_d = mst_mie_q;
        mtvec_out_d   = mtvec_q;
        mepc_out_d    = mepc_q;
`ifdef CSR_CNT_INHIBIT_EN
        cy_inh_d      = cy_inh_q;
        ir_inh_d      = ir_inh_q;
        if (cy_inh_q) mcycle_d = mcycle_q;
        if (ir_inh_q) minstret_d = minstret_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    src_zero_d  = req_src_zero;
                    req_ready_d = 1'b0;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                resp_rdata_d = err ? 32'h0 : old_val;
                resp_err_d   = err;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A committed counter write overrides that half's increment
        if (wr_en) begin
            case (addr_q)
                12'h300: begin mst_mie_d = new_val[3]; mst_mpie_d = new_val[7]; end
                12'h304: irq_en_d = {new_val[11], new_val[7], new_val[3]};
                12'h305: mtvec_d = {new_val[31:2], 2'b00};
`ifdef CSR_CNT_INHIBIT_EN
                12'h320: begin cy_inh_d = new_val[0]; ir_inh_d = new_val[2]; end
`endif
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d = {new_val[31:2], 2'b00};
                12'h342: mcause_d = new_val;
                12'hB00: mcycle_d[31:0] = new_val;
                12'hB80: mcycle_d[63:32] = new_val;
                12'hB02: minstret_d[31:0] = new_val;
                12'hB82: minstret_d[63:32] = new_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            src_zero_q    <= 1'b0;
            mst_mie_q     <= 1'b0;
            mst_mpie_q    <= 1'b0;
            irq_en_q      <= '0;
            mtvec_q       <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mcycle_q      <= '0;
            minstret_q    <= '0;
            mstatus_mie_q <= 1'b0;
            mtvec_out_q   <= {MTVEC_RESET[31:2], 2'b00};
            mepc_out_q    <= '0;
`ifdef CSR_CNT_INHIBIT_EN
            cy_inh_q      <= 1'b0;
            ir_inh_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            src_zero_q    <= src_zero_d;
            mst_mie_q     <= mst_mie_d;
            mst_mpie_q    <= mst_mpie_d;
            irq_en_q      <= irq_en_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
            mstatus_mie_q <= mstatus_mie_d;
            mtvec_out_q   <= mtvec_out_d;
            mepc_out_q    <= mepc_out_d;
`ifdef CSR_CNT_INHIBIT_EN
            cy_inh_q      <= cy_inh_d;
            ir_inh_q      <= ir_inh_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mstatus_mie = mstatus_mie_q;
    assign mtvec_out   = mtvec_out_q;
    assign mepc_out    = mepc_out_q;
endmodule

// File: tb/tb_csr_write_unit.sv
// Directed self-checking bench for csr_write_unit.
// Build with CSR_CNT_INHIBIT_EN to exercise mcountinhibit instead of its unmapped error.
module tb_csr_write_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_src_zero = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        retire = 1'b0;
    logic        mstatus_mie;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd, rd2;
    logic        er;
    int          lat;

    always #5 clk = ~clk;

    csr_write_unit #(.MTVEC_RESET(32'h0000_1003), .CYCLE_OFFSET(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_src_zero(req_src_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .retire(retire),
        .mstatus_mie(mstatus_mie), .mtvec_out(mtvec_out), .mepc_out(mepc_out)
    );

    // Issue one op from IDLE, optionally pulse retire on the commit edge,
    // capture the response and complete the handshake.
    task automatic do_op(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic sz, input logic ret_c,
                         output logic [31:0] rdata, output logic err, output int l);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_wdata = wd; req_src_zero = sz;
        @(posedge clk); #1;
        req_valid = 1'b0;
        retire = ret_c;
        l = 1;
        while (!resp_valid && l < 10) begin
            @(posedge clk); #1;
            retire = 1'b0;
            l++;
        end
        retire = 1'b0;
        rdata = resp_rdata;
        err = resp_err;
        checks++;
        if (!resp_valid) begin
            errors++;
            $display("FAIL resp_timeout addr=%h got valid=%b want 1", addr, resp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic rd_csr(input logic [11:0] addr, output logic [31:0] rdata, output logic err);
        int l;
        do_op(2'b10, addr, 32'h0, 1'b1, 1'b0, rdata, err, l);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", resp_err); end
        checks++; if (mstatus_mie !== 1'b0) begin errors++; $display("FAIL rst_mie got %b want 0", mstatus_mie); end
        checks++; if (mtvec_out !== 32'h0000_1000) begin errors++; $display("FAIL rst_mtvec got %h want 00001000", mtvec_out); end
        checks++; if (mepc_out !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h want 0", mepc_out); end
    endtask

    task automatic test_scratch;
        do_op(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rw_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rw_old got %h want 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rw_err got %b want 0", er); end
        rd_csr(12'h340, rd, er);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_rd got %h want deadbeef", rd); end
        do_op(2'b10, 12'h340, 32'h0000_0110, 1'b0, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_old got %h want deadbeef", rd); end
        do_op(2'b11, 12'h340, 32'hFFFF_FFFF, 1'b1, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BFFF) begin errors++; $display("FAIL rs_new got %h want deadbfff", rd); end
        rd_csr(12'h340, rd, er);
        checks++; if (rd !== 32'hDEAD_BFFF) begin errors++; $display("FAIL rc_suppress got %h want deadbfff", rd); end
    endtask

    task automatic test_machine_csrs;
        do_op(2'b10, 12'h300, 32'h0000_0088, 1'b0, 1'b0, rd, er, lat);
        checks++; if (mstatus_mie !== 1'b1) begin errors++; $display("FAIL mie_set got %b want 1", mstatus_mie); end
        do_op(2'b11, 12'h300, 32'h0000_0008, 1'b0, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'h88) begin errors++; $display("FAIL mstatus_old got %h want 88", rd); end
        checks++; if (mstatus_mie !== 1'b0) begin errors++; $display("FAIL mie_clr got %b want 0", mstatus_mie); end
        rd_csr(12'h300, rd, er);
        checks++; if (rd !== 32'h80) begin errors++; $display("FAIL mpie_kept got %h want 80", rd); end
        do_op(2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, er, lat);
        rd_csr(12'h300, rd, er);
        checks++; if (rd !== 32'h88) begin errors++; $display("FAIL mstatus_mask got %h want 88", rd); end
        do_op(2'b01, 12'h304, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, er, lat);
        rd_csr(12'h304, rd, er);
        checks++; if (rd !== 32'h888) begin errors++; $display("FAIL mie_mask got %h want 888", rd); end
        do_op(2'b01, 12'h305, 32'h1234_5677, 1'b0, 1'b0, rd, er, lat);
        checks++; if (rd !== 32'h0000_1000) begin errors++; $display("FAIL mtvec_old got %h want 00001000", rd); end
        checks++; if (mtvec_out !== 32'h1234_5674) begin errors++; $display("FAIL mtvec_out got %h want 12345674", mtvec_out); end
        do_op(2'b01, 12'h341, 32'h8000_0007, 1'b0, 1'b0, rd, er, lat);
        checks++; if (mepc_out !== 32'h8000_0004) begin errors++; $display("FAIL mepc_out got %h want 80000004", mepc_out); end
        do_op(2'b01, 12'h342, 32'h8000_000B, 1'b0, 1'b0, rd, er, lat);
        rd_csr(12'h342, rd, er);
        checks++; if (rd !== 32'h8000_000B) begin errors++; $display("FAIL mcause got %h want 8000000b", rd); end
    endtask

    task automatic test_mcycle_wrap;
        do_op(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, er, lat);
        repeat (4) @(posedge clk);
        #1;
        rd_csr(12'hB80, rd, er);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mcycleh_inc got %h want 1", rd); end
        rd_csr(12'hB00, rd, er);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL mcycle_wrap got %h want 5", rd); end
    endtask

    task automatic test_minstret;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b10; req_addr = 12'h340;
        req_wdata = 32'h0; req_src_zero = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", resp_valid); end
        retire = 1'b1;
        repeat (10) @(posedge clk);
        #1 retire = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEAD_BFFF) begin errors++; $display("FAIL stall_rdata got %h want deadbfff", resp_rdata); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
        end
        rd_csr(12'hB02, rd, er);
        checks++; if (rd !== 32'd10) begin errors++; $display("FAIL minstret_10 got %0d want 10", rd); end
        retire = 1'b1;
        repeat (10) @(posedge clk);
        #1 retire = 1'b0;
        do_op(2'b01, 12'hB02, 32'd5, 1'b0, 1'b1, rd, er, lat);
        checks++; if (rd !== 32'd20) begin errors++; $display("FAIL minstret_20 got %0d want 20", rd); end
        rd_csr(12'hB02, rd, er);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL minstret_wr got %0d want 5", rd); end
        rd_csr(12'hB82, rd, er);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL minstreth got %0d want 0", rd); end
        rd_csr(12'hC02, rd, er);
        checks++; if (rd !== 32'd5 || er !== 1'b0) begin
            errors++; $display("FAIL instret_ro got %0d err=%b want 5 err=0", rd, er);
        end
    endtask

    task automatic test_errors;
        do_op(2'b01, 12'h7C0, 32'h1, 1'b0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL unmapped got %h err=%b want 0 err=1", rd, er); end
        do_op(2'b01, 12'hC00, 32'h55, 1'b0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ro_write got %h err=%b want 0 err=1", rd, er); end
        do_op(2'b00, 12'h340, 32'h1, 1'b0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL op00 got %h err=%b want 0 err=1", rd, er); end
        rd_csr(12'h340, rd, er);
        checks++; if (rd !== 32'hDEAD_BFFF) begin errors++; $display("FAIL err_nowrite got %h want deadbfff", rd); end
`ifdef CSR_CNT_INHIBIT_EN
        do_op(2'b01, 12'h320, 32'h1, 1'b0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL inhibit_err got %b want 0", er); end
        rd_csr(12'hB00, rd, er);
        repeat (8) @(posedge clk);
        #1;
        rd_csr(12'hB00, rd2, er);
        checks++; if (rd2 !== rd) begin errors++; $display("FAIL cy_frozen got %h want %h", rd2, rd); end
`else
        do_op(2'b01, 12'h320, 32'h1, 1'b0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL inhibit_unmapped got %h err=%b want 0 err=1", rd, er); end
`endif
    endtask

    task automatic test_reset_mid_op;
        req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h341;
        req_wdata = 32'h1003; req_src_zero = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", resp_valid); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL abort_idle got r=%b v=%b want r=1 v=0", req_ready, resp_valid);
        end
        checks++; if (mepc_out !== 32'h0) begin errors++; $display("FAIL abort_mepc got %h want 0", mepc_out); end
        rd_csr(12'h341, rd, er);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_mepc_rd got %h want 0", rd); end
        rd_csr(12'h340, rd, er);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_scratch got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_machine_csrs();
        test_mcycle_wrap();
        test_minstret();
        test_errors();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/csr_write_unit.md
Name: csr_write_unit

Overview:
- Machine-mode CSR write path for the RV32 core. Executes CSRRW/CSRRS/CSRRC and their immediate forms through a read-modify-write FSM.
- Owns the writable machine CSRs and the writable mcycle/minstret counters.
- Sits beside the read-only counter read path in EX. Returns the old CSR value to writeback through a valid/ready response.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0)
- CYCLE_OFFSET, 3, pipeline-fill offset subtracted from raw cycle count on mcycle/mcycleh reads

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-low reset
- req_valid  input  1  CSR op request
- req_ready  output  1  unit idle, can accept
- req_op  input  2  01=RW, 10=RS, 11=RC, 00=reserved
- req_addr  input  12  CSR address
- req_wdata  input  32  rs1 value or zero-extended uimm
- req_src_zero  input  1  rs1==x0 / uimm==0
- resp_valid  output  1  response available
- resp_ready  input  1  writeback accepts response
- resp_rdata  output  32  CSR value before the write
- resp_err  output  1  illegal access
- retire  input  1  one-cycle pulse per retired instruction
- mstatus_mie  output  1  global interrupt enable
- mtvec_out  output  32  trap vector
- mepc_out  output  32  exception PC

Behaviour:
- Reset: rst is synchronous and active-low; it is sampled on posedge clk while low.
  - Values after reset: FSM=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - All CSRs reset to 0, except mtvec=MTVEC_RESET with bits [1:0]=0.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch op/addr/wdata/src_zero and go to EXEC.
  - EXEC: req_ready=0. Decode the address and capture the old value into resp_rdata.
    - new value: RW=wdata; RS=old|wdata; RC=old&~wdata.
    - Commit the write at the end of EXEC, then go to RESP.
  - RESP: resp_valid=1, with resp_rdata/resp_err held stable. On resp_ready, go to IDLE.
- Latency: request accepted at edge N, write visible after edge N+1, resp_valid high from cycle N+2. Throughput is at most one op per 3 cycles.
- Write suppression: RS/RC with req_src_zero=1 does not write. The read still occurs, and no error is raised for read-only fields.
- Address map and writable fields:
  - 0x300 mstatus: bit3 MIE and bit7 MPIE writable; other bits read 0.
  - 0x304 mie: bits 3, 7, 11 writable.
  - 0x305 mtvec: bits [1:0] read 0.
  - 0x340 mscratch: full 32 bits writable.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause: full 32 bits writable.
  - 0xB00/0xB80: mcycle low/high halves.
  - 0xB02/0xB82: minstret low/high halves.
- Counters (64-bit, wrap to 0 past 2^64-1):
  - mcycle increments every cycle; minstret increments on a retire pulse.
  - A committing write to either half replaces that half with the new value; the other half keeps its incremented value. The write has precedence over the increment in the same cycle.
  - mcycle/mcycleh reads return raw-CYCLE_OFFSET (64-bit subtract); the write value is stored raw.
- Errors: the following set resp_err=1, perform no write, and return resp_rdata=0:
  - an unmapped address;
  - req_op=00;
  - any write to 0xC00-0xC82.
- Response stall: retire and mcycle keep counting while RESP stalls.
- Reset mid-op: reset in EXEC or RESP aborts the op; no partial write and no response.
- Side-band outputs: mstatus_mie, mtvec_out and mepc_out are registered copies, updated the cycle after commit.

Optional Feature:
- CSR_CNT_INHIBIT_EN adds mcountinhibit at 0x320. Bit0 CY freezes mcycle and bit2 IR freezes minstret; other bits read 0. Writes to a frozen counter still apply.
- Without the macro, 0x320 is unmapped and raises resp_err=1.

Test Plan:
- Reset, then RW 0x340 with wdata=32'hDEADBEEF -> resp_rdata=0 at N+2. A follow-up RS 0x340 with src_zero=1 returns 32'hDEADBEEF.
- RS 0x300 wdata=32'h0000_0088, then RC 0x300 wdata=32'h0000_0008 -> second response returns 32'h88; mstatus_mie=0, MPIE=1.
- RW 0xB00 wdata=32'hFFFF_FFFF in the same cycle as the increment, then run 4 cycles -> mcycleh increments by 1 and the low half wraps.
- Ten retire pulses during a held resp_ready=0, then read 0xB02 -> 10. Ten more pulses, RW 0xB02 wdata=5 with a retire pulse on the commit cycle -> minstret low half=5.
- RW 0x7C0 and RW 0xC00 -> resp_err=1, resp_rdata=0, no state change. With CSR_CNT_INHIBIT_EN: RW 0x320=32'h1 -> mcycle frozen over 8 cycles.
- Assert rst=0 during EXEC of RW 0x341=32'h1003 -> mepc_out=0, no resp_valid, req_ready=1 the cycle after reset deasserts.
